// File: rtl/sum_stream_buffer.sv
// sum_stream_buffer
//
// Sits behind the adding machine. It captures every valid 32-bit running sum
// into a small FIFO and hands the sums to a slower reader over valid/ready.
// Samples that arrive while the FIFO is full (and nothing leaves that cycle)
// are discarded and counted. A sticky flag records accumulator wrap-around,
// meaning an accepted sum that is unsigned-smaller than the previously
// accepted one.
//
// Ports
//   clk        : single clock; all state updates on the rising edge
//   reset      : synchronous, active-high; clears all control state
//   in_valid   : a running sum is present on in_data this cycle
//   in_data    : running sum from the adding machine
//   out_data   : head-of-FIFO entry, 0 when empty
//   out_valid  : FIFO non-empty
//   out_ready  : reader takes out_data this cycle
//   count      : number of stored entries, 0..DEPTH
//   full       : count == DEPTH
//   empty      : count == 0
//   drop_count : saturating count of rejected samples
//   wrap_flag  : sticky wrap-around indicator
//
// DEPTH must be a power of 2 (at least 2), and ADDR_W must equal log2(DEPTH).
// This lets the pointers wrap through plain ADDR_W-bit overflow.

module sum_stream_buffer #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [15:0]       drop_count,
  output logic              wrap_flag
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  // Storage is never reset; the pointers and count decide what is live.
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [15:0]       r_drop_cnt;
  logic              r_wrap;
  logic              r_prev_valid;
  logic [WIDTH-1:0]  r_prev_sum;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_wrap_hit;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    sat_inc16 = (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  // full/empty come from the count. Pointer equality cannot tell them apart.
  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);

  // When full, a push is still accepted if the head leaves in the same cycle.
  assign w_pop      = !w_empty && out_ready;
  assign w_push     = in_valid && (!w_full || w_pop);
  assign w_drop     = in_valid && w_full && !w_pop;
  assign w_wrap_hit = r_prev_valid && (in_data < r_prev_sum);

  // ---- storage write ----
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // ---- control state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_drop_cnt   <= '0;
      r_wrap       <= 1'b0;
      r_prev_valid <= 1'b0;
      r_prev_sum   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_drop) begin
        r_drop_cnt <= sat_inc16(r_drop_cnt);
      end
      // Only accepted samples take part in wrap tracking.
      if (w_push) begin
        if (w_wrap_hit) begin
          r_wrap <= 1'b1;
        end
        r_prev_sum   <= in_data;
        r_prev_valid <= 1'b1;
      end
    end
  end

  // ---- outputs, from registered state only ----
  assign out_valid  = !w_empty;
  assign out_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count      = r_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign drop_count = r_drop_cnt;
  assign wrap_flag  = r_wrap;

endmodule

// File: tb/tb_sum_stream_buffer.sv
module tb_sum_stream_buffer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] drop_count;
  logic        wrap_flag;

  int errors;
  int checks;

  sum_stream_buffer #(.WIDTH(32), .DEPTH(4), .ADDR_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .drop_count (drop_count),
    .wrap_flag  (wrap_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty cyc%0d got=%b exp=1", i, empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full cyc%0d got=%b exp=0", i, full); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count cyc%0d got=%0d exp=0", i, count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid cyc%0d got=%b exp=0", i, out_valid); end
      checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data cyc%0d got=%h exp=0", i, out_data); end
      checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop cyc%0d got=%0d exp=0", i, drop_count); end
      checks++; if (wrap_flag !== 1'b0) begin errors++; $display("FAIL reset_wrap cyc%0d got=%b exp=0", i, wrap_flag); end
      step();
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] vals [4];
    vals = '{32'd10, 32'd20, 32'd30, 32'd40};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_one(vals[i]);
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count i%0d got=%0d exp=%0d", i, count, i + 1); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_out_valid got=%b exp=1", out_valid); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== vals[i]) begin errors++; $display("FAIL drain_data i%0d got=%0d exp=%0d", i, out_data, vals[i]); end
      step();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL drain_out_data got=%h exp=0", out_data); end
    // Reader still asserting ready on an empty FIFO changes nothing.
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_pop_valid got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow_drop();
    logic [31:0] vals [4];
    vals = '{32'd11, 32'd22, 32'd33, 32'd44};
    do_reset();
    for (int i = 0; i < 4; i++) push_one(vals[i]);
    in_valid = 1'b1; in_data = 32'd99;
    step(); step(); step();
    in_valid = 1'b0;
    checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL ovf_drop got=%0d exp=3", drop_count); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== vals[i]) begin errors++; $display("FAIL ovf_drain i%0d got=%0d exp=%0d", i, out_data, vals[i]); end
      step();
    end
    out_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got=%b exp=1", empty); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_v [4];
    exp_v = '{32'd2, 32'd3, 32'd4, 32'd50};
    do_reset();
    push_one(32'd1); push_one(32'd2); push_one(32'd3); push_one(32'd4);
    in_valid = 1'b1; in_data = 32'd50; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL pp_count got=%0d exp=4", count); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL pp_drop got=%0d exp=0", drop_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== exp_v[i]) begin errors++; $display("FAIL pp_drain i%0d got=%0d exp=%0d", i, out_data, exp_v[i]); end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    push_one(32'hFFFF_FFF0);
    checks++; if (wrap_flag !== 1'b0) begin errors++; $display("FAIL wrap_first got=%b exp=0", wrap_flag); end
    push_one(32'hFFFF_FFF8);
    checks++; if (wrap_flag !== 1'b0) begin errors++; $display("FAIL wrap_second got=%b exp=0", wrap_flag); end
    push_one(32'h0000_0004);
    checks++; if (wrap_flag !== 1'b1) begin errors++; $display("FAIL wrap_third got=%b exp=1", wrap_flag); end
    push_one(32'd10); push_one(32'd20);
    checks++; if (wrap_flag !== 1'b1) begin errors++; $display("FAIL wrap_sticky got=%b exp=1", wrap_flag); end
    out_ready = 1'b0;

    // Equal consecutive sums are not a wrap.
    do_reset();
    push_one(32'd7); push_one(32'd7);
    checks++; if (wrap_flag !== 1'b0) begin errors++; $display("FAIL wrap_equal got=%b exp=0", wrap_flag); end

    // Dropped samples never touch wrap tracking.
    do_reset();
    push_one(32'd100); push_one(32'd200); push_one(32'd300); push_one(32'd400);
    push_one(32'd5);
    checks++; if (wrap_flag !== 1'b0) begin errors++; $display("FAIL wrap_drop_small got=%b exp=0", wrap_flag); end
    push_one(32'd1000);
    in_valid = 1'b1; in_data = 32'd450; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (wrap_flag !== 1'b0) begin errors++; $display("FAIL wrap_prev_kept got=%b exp=0", wrap_flag); end
    checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL wrap_drop_cnt got=%0d exp=2", drop_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_one(32'd100); push_one(32'd50); push_one(32'd60); push_one(32'd70);
    push_one(32'd80); push_one(32'd90);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
    checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL mid_pre_drop got=%0d exp=2", drop_count); end
    checks++; if (wrap_flag !== 1'b1) begin errors++; $display("FAIL mid_pre_wrap got=%b exp=1", wrap_flag); end
    reset = 1'b1; in_valid = 1'b1; in_data = 32'd123; out_ready = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL mid_drop got=%0d exp=0", drop_count); end
    checks++; if (wrap_flag !== 1'b0) begin errors++; $display("FAIL mid_wrap got=%b exp=0", wrap_flag); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    push_one(32'd7);
    checks++; if (out_data !== 32'd7) begin errors++; $display("FAIL mid_readback got=%0d exp=7", out_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL mid_count1 got=%0d exp=1", count); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid1 got=%b exp=1", out_valid); end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    test_reset();
    test_fill_drain();
    test_overflow_drop();
    test_full_push_pop();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
